// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// frame constants and the running-checksum helper.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;
  localparam int BYTE_WIDTH  = 8;
  localparam int WORD_WIDTH  = 32;
  localparam int COUNT_WIDTH = 16;

  function automatic logic [BYTE_WIDTH-1:0] csum_update(
    input logic [BYTE_WIDTH-1:0] acc,
    input logic [BYTE_WIDTH-1:0] data
  );
    return acc ^ data;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream boot loader: assembles big-endian words into instruction
// memory and holds the core in reset until the frame checksum verifies.
module imem_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  reload,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           load_base
);

  // Count compares run one bit wider so N = 2^ADDR_WIDTH fits without wrapping.
  localparam logic [COUNT_WIDTH:0] CAPACITY = {{COUNT_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;
  localparam logic [COUNT_WIDTH:0] ONE_EXT  = {{COUNT_WIDTH{1'b0}}, 1'b1};

  state_t                   state_r, next_state_s;
  logic [COUNT_WIDTH-1:0]   count_r;
  logic [ADDR_WIDTH:0]      word_idx_r;
  logic [1:0]               byte_cnt_r;
  logic [23:0]              asm_r;
  logic [BYTE_WIDTH-1:0]    xor_r;
  logic                     rx_ready_r, cpu_rst_r, done_r, err_r;
  logic                     rx_ready_s, cpu_rst_s, done_s, err_s;
  logic                     im_we_r;
  logic [ADDR_WIDTH-1:0]    im_addr_r;
  logic [WORD_WIDTH-1:0]    im_wdata_r;
  logic                     xfer_s, word_done_s, last_word_s, reload_s;
  logic [COUNT_WIDTH:0]     len_s, next_word_s;

  assign xfer_s      = rx_valid & rx_ready_r;
  assign word_done_s = (state_r == ST_DATA) & xfer_s & (byte_cnt_r == 2'd3);
  assign reload_s    = reload & ((state_r == ST_DONE) | (state_r == ST_ERR));
  assign len_s       = {1'b0, count_r[15:8], rx_data};
  assign next_word_s = (COUNT_WIDTH+1)'(word_idx_r) + ONE_EXT;
  assign last_word_s = (next_word_s == {1'b0, count_r});

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   if (xfer_s && rx_data == LOADER_MAGIC) next_state_s = ST_LEN_HI;
                 else next_state_s = ST_IDLE;
      ST_LEN_HI: if (xfer_s) next_state_s = ST_LEN_LO;
                 else next_state_s = ST_LEN_HI;
      ST_LEN_LO: begin
        if (!xfer_s)                           next_state_s = ST_LEN_LO;
        else if (len_s > CAPACITY)             next_state_s = ST_ERR;
        else if (len_s == {(COUNT_WIDTH+1){1'b0}}) next_state_s = ST_CSUM;
        else                                   next_state_s = ST_DATA;
      end
      ST_DATA:   if (word_done_s && last_word_s) next_state_s = ST_CSUM;
                 else next_state_s = ST_DATA;
      ST_CSUM: begin
        if (!xfer_s)              next_state_s = ST_CSUM;
        else if (rx_data == xor_r) next_state_s = ST_DONE;
        else                      next_state_s = ST_ERR;
      end
      ST_DONE:   if (reload) next_state_s = ST_IDLE;
                 else next_state_s = ST_DONE;
      ST_ERR:    if (reload) next_state_s = ST_IDLE;
                 else next_state_s = ST_ERR;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the status outputs can be registered
  always_comb begin
    rx_ready_s = 1'b1;
    cpu_rst_s  = 1'b1;
    done_s     = 1'b0;
    err_s      = 1'b0;
    case (next_state_s)
      ST_DONE: begin rx_ready_s = 1'b0; cpu_rst_s = 1'b0; done_s = 1'b1; end
      ST_ERR:  begin rx_ready_s = 1'b0; err_s = 1'b1; end
      default: begin rx_ready_s = 1'b1; cpu_rst_s = 1'b1; end
    endcase
  end

  // Status output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready_r <= 1'b1;
      cpu_rst_r  <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      rx_ready_r <= rx_ready_s;
      cpu_rst_r  <= cpu_rst_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  // Frame datapath: length capture, byte assembly, word index and checksum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r    <= {COUNT_WIDTH{1'b0}};
      word_idx_r <= {(ADDR_WIDTH+1){1'b0}};
      byte_cnt_r <= 2'd0;
      asm_r      <= 24'd0;
      xor_r      <= 8'd0;
    end else if (reload_s) begin
      word_idx_r <= {(ADDR_WIDTH+1){1'b0}};
      byte_cnt_r <= 2'd0;
      xor_r      <= 8'd0;
    end else begin
      case (state_r)
        ST_LEN_HI: if (xfer_s) count_r[15:8] <= rx_data;
        ST_LEN_LO: if (xfer_s) count_r[7:0]  <= rx_data;
        ST_DATA: begin
          if (xfer_s) begin
            asm_r      <= {asm_r[15:0], rx_data};
            byte_cnt_r <= byte_cnt_r + 2'd1;
            xor_r      <= csum_update(xor_r, rx_data);
            if (byte_cnt_r == 2'd3) word_idx_r <= word_idx_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  // Instruction-memory write port, one strobe per completed word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_we_r    <= 1'b0;
      im_addr_r  <= {ADDR_WIDTH{1'b0}};
      im_wdata_r <= 32'd0;
    end else begin
      im_we_r <= word_done_s;
      if (word_done_s) begin
        im_addr_r  <= word_idx_r[ADDR_WIDTH-1:0];
        im_wdata_r <= {asm_r, rx_data};
      end
    end
  end

  assign rx_ready  = rx_ready_r;
  assign cpu_rst   = cpu_rst_r;
  assign done      = done_r;
  assign err       = err_r;
  assign im_we     = im_we_r;
  assign im_addr   = im_addr_r;
  assign im_wdata  = im_wdata_r;
  assign load_base = TEXT_BASE;

endmodule
